inv_bank_sched: RTL
===================

# inv_bank_sched

Controller that shares one combinational inverter-bank datapath, a `not`-primitive slice with a 5-bit output, among several requesters. It arbitrates requests round-robin and drives the shared datapath input. After a fixed settle latency it samples the datapath output, converts it from 4-state to 2-state, and returns the result tagged with the requester ID. It sits between the requester ports and the gate-primitive datapath; only one operation is in flight at a time.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters (2..8).
- `DW`, default 5: datapath width in bits.
- `LAT`, default 2: datapath settle cycles before sampling (1..15).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, `NREQ`: per-requester request strobe.
- `req_ready`, output, `NREQ`: per-requester grant; one-hot or zero.
- `req_data`, input, `NREQ`×`DW` (packed `[NREQ-1:0][DW-1:0]`): operand per requester.
- `dp_in`, output, `DW` (logic): drive to the shared datapath input.
- `dp_en`, output, 1: high while `dp_in` holds a live operand.
- `dp_out`, input, `DW` (logic, 4-state): datapath result.
- `resp_valid`, output, 1: result available.
- `resp_ready`, input, 1: consumer accepts the result.
- `resp_id`, output, `$clog2(NREQ)`: requester index of the result.
- `resp_data`, output, `DW` (bit, 2-state): sampled result, with X/Z mapped to 0.
- `resp_xz`, output, 1: any bit of the sampled `dp_out` was X or Z.

## Operation
- FSM states: IDLE, DRIVE, RESP.
- **IDLE**
  - If any `req_valid` is set, assert `req_ready` combinationally for the round-robin winner.
  - Search order starts at `(last_grant+1) mod NREQ`.
  - A handshake (`req_valid[i] & req_ready[i]`) latches `req_data[i]` into the operand register and `i` into `id_q`.
  - Set `last_grant=i` and go to DRIVE.
- **DRIVE**
  - `dp_in` = operand register and `dp_en`=1.
  - A 4-bit settle counter loads `LAT-1` on entry and decrements each cycle.
  - In the cycle where the counter is 0, `dp_out` is sampled, then go to RESP.
  - `resp_data[b] = (dp_out[b]===1'b1)`.
  - `resp_xz = |(dp_out ^ dp_out) !== 0`, i.e. any bit is X or Z.
- **RESP**
  - `resp_valid`=1; `resp_id`, `resp_data` and `resp_xz` are held stable until `resp_ready`.
  - On `resp_valid & resp_ready`, go to IDLE.
  - `dp_en`=0 and `dp_in` = all zeros.
- `req_ready` is all zeros outside IDLE.
- `req_valid` may drop without a handshake; no grant state is kept for it.
- Round-robin pointer: `last_grant` resets to `NREQ-1`, so requester 0 wins first. With a single requester active, it wins every time.
- No pointer update when no grant occurs.
- Reset mid-operation (any state) aborts immediately:
  - state=IDLE, counter=0, operand=0, `id_q`=0, `last_grant=NREQ-1`;
  - all outputs return to reset values asynchronously;
  - the in-flight result is discarded.
- Reset values: `req_ready`=0 while `rst_n`=0, `dp_in`=0, `dp_en`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_xz`=0.

## Timing
- Handshake on cycle T:
  - `dp_en` rises at T+1 and stays high for exactly `LAT` cycles (T+1..T+LAT);
  - `dp_out` is sampled on the clock edge ending cycle T+LAT;
  - `resp_valid` is high from T+LAT+1.
- If `resp_ready` is already high at T+LAT+1, that is the response handshake cycle. IDLE is at T+LAT+2, so the next grant can come no earlier than T+LAT+2.
- Back-to-back minimum period per operation: `LAT`+2 cycles.
- `req_ready` is a combinational function of `req_valid`, state and pointer only; there is no path from `dp_out` to `req_ready`.
- `resp_*` are registered outputs.
- Async reset is asserted without a clock; deassertion is synchronised externally. The first grant is possible in the first active edge after release.

## Test plan
- Single request, LAT=2:
  - stimulus: `req_valid`=4'b0001, `req_data[0]`=5'b10101, datapath = bitwise NOT, `resp_ready`=1;
  - required: `dp_en` high exactly 2 cycles, `resp_valid` at T+3, `resp_id`=0, `resp_data`=5'b01010, `resp_xz`=0.
- Round-robin fairness:
  - stimulus: all 4 `req_valid` held high for 8 operations;
  - required: grant order 0,1,2,3,0,1,2,3, with `req_ready` one-hot in each IDLE grant cycle.
- Response backpressure:
  - stimulus: `resp_ready`=0 for 5 cycles after `resp_valid`;
  - required: `resp_*` stable, `req_ready`=0 throughout; the next grant comes the cycle after the response handshake.
- 4-state conversion:
  - stimulus: `dp_out`=5'b1x0z1 at the sample edge;
  - required: `resp_data`=5'b10001, `resp_xz`=1.
- Reset mid-DRIVE:
  - stimulus: assert `rst_n`=0 one cycle into DRIVE, with a requester still valid;
  - required: `dp_en`, `resp_valid` and `req_ready` drop immediately; after release, requester 0 wins first and no stale response appears.
- LAT=1 boundary:
  - stimulus: `req_valid`=4'b1000;
  - required: `dp_en` high 1 cycle, `resp_valid` at T+2, `resp_id`=3.

Source files
------------

// File: rtl/inv_bank_sched.sv
// inv_bank_sched: round-robin scheduler for one shared combinational inverter-bank datapath.
// Drives the granted operand for LAT cycles, then returns the sampled result as 2-state data.
//
// state | meaning
// IDLE  | arbitrate requesters, accept one operand
// DRIVE | operand on dp_in, settle counter running
// RESP  | result held on resp_* until accepted
module inv_bank_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 5,
  parameter int LAT  = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0][DW-1:0] req_data,
  output logic [DW-1:0]           dp_in,
  output logic                    dp_en,
  input  logic [DW-1:0]           dp_out,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IW-1:0]           resp_id,
  output bit   [DW-1:0]           resp_data,
  output logic                    resp_xz
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0]    CNT_LOAD = 4'(LAT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt_q;
  logic [DW-1:0] op_q;
  logic [IW-1:0] id_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] win_id;
  logic [IW-1:0] idx;
  logic          win_any;

  // Walk downwards so the candidate nearest to last_q+1 is the one left standing.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (req_valid[idx]) begin
        win_any = 1'b1;
        win_id  = idx;
      end
    end
  end

  // Gated by rst_n so no grant is visible while the block is held in reset.
  assign req_ready = (rst_n && state == IDLE && win_any) ? (NREQ'(1) << win_id) : '0;
  assign dp_en     = (state == DRIVE);
  assign dp_in     = (state == DRIVE) ? op_q : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_any) state_nxt = DRIVE;
      DRIVE:   if (cnt_q == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      id_q       <= '0;
      last_q     <= LAST_RST;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_xz    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (win_any) begin
            op_q   <= req_data[win_id];
            id_q   <= win_id;
            last_q <= win_id;
            cnt_q  <= CNT_LOAD;
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            resp_valid <= 1'b1;
            resp_id    <= id_q;
            // x^x and z^z stay unknown, so any non-0/1 bit makes the xor non-zero
            resp_xz    <= ((dp_out ^ dp_out) !== '0);
            for (int b = 0; b < DW; b++) begin
              resp_data[b] <= (dp_out[b] === 1'b1);
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
